jtdd_obj_rom_slot: RTL



---
 rtl/jtdd_obj_rom_slot.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/jtdd_obj_rom_slot.sv
// Object-layer ROM slot: a 2-entry, 32-bit-line cache in front of the SDRAM arbiter.
// Hits answer combinationally; a miss becomes one 32-bit line read on the backend.
module jtdd_obj_rom_slot #(
  parameter int             AW     = 19,
  parameter int             SDW    = 22,
  parameter logic [SDW-1:0] OFFSET = 22'h0
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cs,
  input  logic [AW-1:0]  addr,
  output logic [15:0]    dout,
  output logic           ok,
  output logic [SDW-1:0] mem_addr,
  output logic           mem_req,
  input  logic           mem_ack,
  input  logic           mem_rdy,
  input  logic [31:0]    mem_data
);

  localparam int TW = AW - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_r, state_s;
  logic [1:0]      valid_r;
  logic [TW-1:0]   tag_r [2];
  logic [31:0]     data_r [2];
  logic [TW-1:0]   ltag_r;
  logic            lru_r;
  logic            pending_r;
  logic            pend_rst_s;

  logic [TW-1:0]   req_tag_s;
  logic [SDW-1:0]  line_addr_s;
  logic [1:0]      hit_s;
  logic [1:0]      dup_s;
  logic            victim_s;
  logic [31:0]     line_s;
  logic            issue_s;
  logic            fill_s;

  assign req_tag_s   = addr[AW-1:1];
  assign line_addr_s = SDW'({req_tag_s, 1'b0});

  // Tag compare against the live address, and duplicate check for the in-flight line
  always_comb begin
    hit_s    = 2'b00;
    dup_s    = 2'b00;
    hit_s[0] = cs & valid_r[0] & (tag_r[0] == req_tag_s);
    hit_s[1] = cs & valid_r[1] & (tag_r[1] == req_tag_s);
    dup_s[0] = valid_r[0] & (tag_r[0] == ltag_r);
    dup_s[1] = valid_r[1] & (tag_r[1] == ltag_r);
    if (dup_s[0]) begin
      victim_s = 1'b0;
    end else if (dup_s[1]) begin
      victim_s = 1'b1;
    end else begin
      victim_s = lru_r;
    end
  end

  // Zero-latency read path; ok drops the same cycle addr leaves a cached line
  always_comb begin
    line_s = 32'h0;
    if (hit_s[0]) begin
      line_s = data_r[0];
    end else if (hit_s[1]) begin
      line_s = data_r[1];
    end else begin
      line_s = 32'h0;
    end
    dout = addr[0] ? line_s[31:16] : line_s[15:0];
    ok   = |hit_s;
  end

  // Next-state logic for the miss handler
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    fill_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (cs && !ok && !pending_r) begin
          issue_s = 1'b1;
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        if (mem_ack && mem_rdy) begin
          fill_s  = 1'b1;
          state_s = IDLE;
        end else if (mem_ack) begin
          state_s = WAIT;
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        if (mem_rdy) begin
          fill_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = WAIT;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // An acked read still owes us one mem_rdy after reset; remember to swallow it
  always_comb begin
    pend_rst_s = (pending_r & ~mem_rdy)
               | ((state_r == WAIT) & ~mem_rdy)
               | ((state_r == REQ) & mem_ack & ~mem_rdy);
  end

  // Control state: FSM, request port, valid bits, LRU and the post-reset discard flag
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      valid_r   <= 2'b00;
      lru_r     <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= {SDW{1'b0}};
      pending_r <= pend_rst_s;
    end else begin
      state_r <= state_s;
      if (issue_s) begin
        mem_req  <= 1'b1;
        mem_addr <= OFFSET + line_addr_s;
      end else if (state_r == REQ && mem_ack) begin
        mem_req  <= 1'b0;
      end else begin
        mem_req  <= mem_req;
      end
      if (state_r == IDLE && pending_r && mem_rdy) begin
        pending_r <= 1'b0;
      end else begin
        pending_r <= pending_r;
      end
      if (fill_s) begin
        valid_r[victim_s] <= 1'b1;
        lru_r             <= ~victim_s;
      end else if (hit_s[0]) begin
        lru_r <= 1'b1;
      end else if (hit_s[1]) begin
        lru_r <= 1'b0;
      end else begin
        lru_r <= lru_r;
      end
    end
  end

  // Line storage and latched miss tag; validity is tracked separately so no reset needed
  always_ff @(posedge clk) begin
    if (issue_s && rst_n) begin
      ltag_r <= req_tag_s;
    end
    if (fill_s && rst_n) begin
      tag_r[victim_s]  <= ltag_r;
      data_r[victim_s] <= mem_data;
    end
  end

endmodule
